// File: rtl/sprite_compositor.sv
// sprite_compositor: two-stage RGB332 compositor of one background layer and
// NUM_SPR sprite layers. Stage A issues the background and sprite ROM
// addresses and latches the hit flags. Stage B picks the winning pixel from
// the returned ROM bytes. Sprite registers are double-buffered and are copied
// from pending to active at the frame tick.
// Optional feature macro: COLLISION_EN (per-frame sprite-0 collision flags).
module sprite_compositor #(
    parameter int unsigned NUM_SPR    = 4,
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 16,
    parameter int unsigned SPR_FRAMES = 2,
    parameter int unsigned SPR_AW     = 9,
    parameter int unsigned FRM_W      = 1,
    parameter logic [7:0]  TRANSP_KEY = 8'hE3,
    parameter int unsigned TICK_LINE  = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_ce,
    input  logic [9:0]                x_ptr,
    input  logic [9:0]                y_ptr,
    input  logic                      valid_in,
    input  logic                      wr_en,
    input  logic [2:0]                wr_idx,
    input  logic [9:0]                wr_x,
    input  logic [9:0]                wr_y,
    input  logic [FRM_W-1:0]          wr_frame,
    input  logic                      wr_vis,
    output logic [15:0]               bg_addr,
    input  logic [7:0]                bg_data,
    output logic [NUM_SPR*SPR_AW-1:0] spr_addr,
    input  logic [NUM_SPR*8-1:0]      spr_data,
    output logic [7:0]                rgb,
    output logic                      valid_out,
    output logic                      frame_tick,
    output logic [NUM_SPR-1:0]        collide
);

    localparam int unsigned XW = $clog2(SPR_W);
    localparam int unsigned YW = $clog2(SPR_H);
    // frame index wraps within the frames actually stored in a sprite ROM
    localparam logic [FRM_W-1:0] FRM_MASK = FRM_W'(SPR_FRAMES - 1);

    logic [9:0]                r_pend_x     [NUM_SPR];
    logic [9:0]                r_pend_y     [NUM_SPR];
    logic [FRM_W-1:0]          r_pend_frame [NUM_SPR];
    logic                      r_pend_vis   [NUM_SPR];
    logic [9:0]                r_act_x      [NUM_SPR];
    logic [9:0]                r_act_y      [NUM_SPR];
    logic [FRM_W-1:0]          r_act_frame  [NUM_SPR];
    logic                      r_act_vis    [NUM_SPR];

    logic [NUM_SPR-1:0]        w_wr_sel;
    logic                      w_tick;
    logic [10:0]               w_dx [NUM_SPR];
    logic [10:0]               w_dy [NUM_SPR];
    logic [NUM_SPR-1:0]        w_hit;
    logic [NUM_SPR*SPR_AW-1:0] w_spr_addr;

    logic [NUM_SPR-1:0]        r_hit_a;
    logic                      r_valid_a;
    logic [NUM_SPR-1:0]        w_opaque;
    logic [7:0]                w_pix;

    // Frame tick detection and per-sprite write decode (out-of-range index selects nothing)
    always_comb begin
        w_tick = pix_ce && (x_ptr == '0) && (y_ptr == 10'(TICK_LINE));
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            w_wr_sel[i] = wr_en && (32'(wr_idx) == i);
        end
    end

    // Pending sprite registers: host writes land here on any clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                r_pend_x[i]     <= '0;
                r_pend_y[i]     <= '0;
                r_pend_frame[i] <= '0;
                r_pend_vis[i]   <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                if (w_wr_sel[i]) begin
                    r_pend_x[i]     <= wr_x;
                    r_pend_y[i]     <= wr_y;
                    r_pend_frame[i] <= wr_frame;
                    r_pend_vis[i]   <= wr_vis;
                end
            end
        end
    end

    // Active sprite registers: copied at the tick, a same-clk write goes straight through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                r_act_x[i]     <= '0;
                r_act_y[i]     <= '0;
                r_act_frame[i] <= '0;
                r_act_vis[i]   <= 1'b0;
            end
        end else if (w_tick) begin
            for (int unsigned i = 0; i < NUM_SPR; i++) begin
                r_act_x[i]     <= w_wr_sel[i] ? wr_x     : r_pend_x[i];
                r_act_y[i]     <= w_wr_sel[i] ? wr_y     : r_pend_y[i];
                r_act_frame[i] <= w_wr_sel[i] ? wr_frame : r_pend_frame[i];
                r_act_vis[i]   <= w_wr_sel[i] ? wr_vis   : r_pend_vis[i];
            end
        end
    end

    // Stage A combinational: sprite-relative offsets, hit test (no wrap) and ROM addresses
    always_comb begin
        w_hit      = '0;
        w_spr_addr = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            w_dx[i]  = {1'b0, x_ptr} - {1'b0, r_act_x[i]};
            w_dy[i]  = {1'b0, y_ptr} - {1'b0, r_act_y[i]};
            w_hit[i] = r_act_vis[i]
                       && (x_ptr >= r_act_x[i]) && (w_dx[i] < 11'(SPR_W))
                       && (y_ptr >= r_act_y[i]) && (w_dy[i] < 11'(SPR_H));
            w_spr_addr[i*SPR_AW +: SPR_AW] = {r_act_frame[i] & FRM_MASK,
                                              w_dy[i][YW-1:0], w_dx[i][XW-1:0]};
        end
    end

    // Stage A registers: ROM addresses with hit flags and valid carried alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_addr   <= '0;
            spr_addr  <= '0;
            r_hit_a   <= '0;
            r_valid_a <= 1'b0;
        end else if (pix_ce) begin
            bg_addr   <= {y_ptr[8:1], x_ptr[9:2]};
            spr_addr  <= w_spr_addr;
            r_hit_a   <= w_hit;
            r_valid_a <= valid_in;
        end
    end

    // Stage B combinational: opacity per layer, lowest-index opaque sprite wins over background
    always_comb begin
        w_opaque = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            w_opaque[i] = r_hit_a[i] && (spr_data[i*8 +: 8] != TRANSP_KEY);
        end
        w_pix = bg_data;
        for (int unsigned k = 0; k < NUM_SPR; k++) begin
            if (w_opaque[NUM_SPR-1-k]) begin
                w_pix = spr_data[(NUM_SPR-1-k)*8 +: 8];
            end
        end
    end

    // Stage B registers: composited pixel, blanked outside the visible area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= '0;
            valid_out <= 1'b0;
        end else if (pix_ce) begin
            rgb       <= r_valid_a ? w_pix : '0;
            valid_out <= r_valid_a;
        end
    end

    // Frame tick pulse, one clk wide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_tick;
        end
    end

`ifdef COLLISION_EN
    logic [NUM_SPR-1:0] r_pend_col;
    logic [NUM_SPR-1:0] w_col;

    // Collision of sprite 0 with each other opaque sprite at a visible pixel
    always_comb begin
        w_col = '0;
        for (int unsigned i = 1; i < NUM_SPR; i++) begin
            w_col[i] = r_valid_a && w_opaque[0] && w_opaque[i];
        end
    end

    // Per-frame accumulation; a hit on the tick clk belongs to the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_col <= '0;
            collide    <= '0;
        end else if (pix_ce) begin
            if (w_tick) begin
                collide    <= r_pend_col;
                r_pend_col <= w_col;
            end else begin
                r_pend_col <= r_pend_col | w_col;
            end
        end
    end
`else
    assign collide = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks of sprite_compositor
// against a pixel-level reference model (sprite rectangles, priority, colour
// key, double-buffered registers, frame tick, optional collision flags).
module tb_sprite_compositor;

    localparam int unsigned NUM_SPR    = 4;
    localparam int unsigned SPR_W      = 16;
    localparam int unsigned SPR_H      = 16;
    localparam int unsigned SPR_FRAMES = 2;
    localparam int unsigned SPR_AW     = 9;
    localparam int unsigned FRM_W      = 1;
    localparam logic [7:0]  KEY        = 8'hE3;
    localparam int          TICK_LINE  = 480;
    localparam int unsigned ROM_N      = SPR_W * SPR_H * SPR_FRAMES;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      pix_ce = 1'b0;
    logic [9:0]                x_ptr = '0;
    logic [9:0]                y_ptr = '0;
    logic                      valid_in = 1'b0;
    logic                      wr_en = 1'b0;
    logic [2:0]                wr_idx = '0;
    logic [9:0]                wr_x = '0;
    logic [9:0]                wr_y = '0;
    logic [FRM_W-1:0]          wr_frame = '0;
    logic                      wr_vis = 1'b0;
    logic [15:0]               bg_addr;
    logic [7:0]                bg_data;
    logic [NUM_SPR*SPR_AW-1:0] spr_addr;
    logic [NUM_SPR*8-1:0]      spr_data;
    logic [7:0]                rgb;
    logic                      valid_out;
    logic                      frame_tick;
    logic [NUM_SPR-1:0]        collide;

    always #5 clk = ~clk;

    sprite_compositor #(
        .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .SPR_FRAMES(SPR_FRAMES),
        .SPR_AW(SPR_AW), .FRM_W(FRM_W), .TRANSP_KEY(KEY), .TICK_LINE(TICK_LINE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .x_ptr(x_ptr), .y_ptr(y_ptr),
        .valid_in(valid_in), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_frame(wr_frame), .wr_vis(wr_vis), .bg_addr(bg_addr), .bg_data(bg_data),
        .spr_addr(spr_addr), .spr_data(spr_data), .rgb(rgb), .valid_out(valid_out),
        .frame_tick(frame_tick), .collide(collide)
    );

    // ROM contents seen by the DUT
    logic [7:0] spr_rom [NUM_SPR][ROM_N];
    bit         bg_const = 1'b1;

    function automatic logic [7:0] rom_bg(input bit c, input logic [15:0] a);
        return c ? 8'h1C : (a[7:0] ^ a[15:8] ^ 8'hA5);
    endfunction

    always_comb begin
        bg_data  = rom_bg(bg_const, bg_addr);
        spr_data = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            spr_data[i*8 +: 8] = spr_rom[i][spr_addr[i*SPR_AW +: SPR_AW]];
        end
    end

    // Reference model state
    int                 pm_x [NUM_SPR], pm_y [NUM_SPR], pm_f [NUM_SPR];
    bit                 pm_v [NUM_SPR];
    int                 am_x [NUM_SPR], am_y [NUM_SPR], am_f [NUM_SPR];
    bit                 am_v [NUM_SPR];
    bit                 s_v;
    bit                 s_hit [NUM_SPR];
    int                 s_addr [NUM_SPR];
    int                 s_bg;
    logic [7:0]         e_rgb;
    bit                 e_vout;
    logic [NUM_SPR-1:0] e_col;
`ifdef COLLISION_EN
    logic [NUM_SPR-1:0] p_col;
`endif
    bit                 q_we;
    int                 q_idx, q_x, q_y, q_f;
    bit                 q_vis;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_SPR; i++) begin
            pm_x[i] = 0; pm_y[i] = 0; pm_f[i] = 0; pm_v[i] = 0;
            am_x[i] = 0; am_y[i] = 0; am_f[i] = 0; am_v[i] = 0;
            s_hit[i] = 0; s_addr[i] = 0;
        end
        s_v = 0; s_bg = 0; e_rgb = 8'h00; e_vout = 0; e_col = '0;
`ifdef COLLISION_EN
        p_col = '0;
`endif
        q_we = 0;
    endtask

    task automatic q_write(input int idx, input int x, input int y, input int f, input bit vis);
        q_we = 1; q_idx = idx; q_x = x; q_y = y; q_f = f; q_vis = vis;
    endtask

    // One clk: drive inputs, advance the model, compare every output
    task automatic step(input bit ce, input int x, input int y, input bit v);
        bit         tick;
        bit         n_hit  [NUM_SPR];
        int         n_addr [NUM_SPR];
        bit         op     [NUM_SPR];
        bit         won;
        logic [7:0] pix;
`ifdef COLLISION_EN
        logic [NUM_SPR-1:0] col;
`endif
        @(negedge clk);
        pix_ce = ce; x_ptr = 10'(x); y_ptr = 10'(y); valid_in = v;
        wr_en = q_we; wr_idx = 3'(q_idx); wr_x = 10'(q_x); wr_y = 10'(q_y);
        wr_frame = FRM_W'(q_f); wr_vis = q_vis;
        tick = ce && (x == 0) && (y == TICK_LINE);
        for (int i = 0; i < NUM_SPR; i++) begin
            n_hit[i]  = am_v[i] && x >= am_x[i] && x < am_x[i] + int'(SPR_W)
                        && y >= am_y[i] && y < am_y[i] + int'(SPR_H);
            n_addr[i] = n_hit[i] ? am_f[i] * int'(SPR_W * SPR_H)
                                   + (y - am_y[i]) * int'(SPR_W) + (x - am_x[i]) : 0;
        end
        @(posedge clk);
        #1;
        if (ce) begin
            pix = rom_bg(bg_const, 16'(s_bg));
            won = 0;
            for (int i = 0; i < NUM_SPR; i++) begin
                op[i] = s_hit[i] && (spr_rom[i][s_addr[i]] != KEY);
                if (op[i] && !won) begin
                    pix = spr_rom[i][s_addr[i]];
                    won = 1;
                end
            end
            e_rgb  = s_v ? pix : 8'h00;
            e_vout = s_v;
`ifdef COLLISION_EN
            col = '0;
            for (int i = 1; i < NUM_SPR; i++) col[i] = s_v && op[0] && op[i];
            if (tick) begin
                e_col = p_col;
                p_col = col;
            end else begin
                p_col = p_col | col;
            end
`endif
            s_v  = v;
            s_bg = ((y / 2) % 256) * 256 + (x / 4) % 256;
            for (int i = 0; i < NUM_SPR; i++) begin
                s_hit[i]  = n_hit[i];
                s_addr[i] = n_addr[i];
            end
        end
        if (q_we && q_idx < NUM_SPR) begin
            pm_x[q_idx] = q_x; pm_y[q_idx] = q_y; pm_f[q_idx] = q_f; pm_v[q_idx] = q_vis;
        end
        if (tick) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                am_x[i] = pm_x[i]; am_y[i] = pm_y[i]; am_f[i] = pm_f[i]; am_v[i] = pm_v[i];
            end
        end
        q_we = 0;
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("valid_out", 32'(valid_out), 32'(e_vout));
        check("frame_tick", 32'(frame_tick), 32'(tick));
        check("collide", 32'(collide), 32'(e_col));
        check("bg_addr", 32'(bg_addr), s_bg);
        for (int i = 0; i < NUM_SPR; i++) begin
            if (s_hit[i]) check("spr_addr", 32'(spr_addr[i*SPR_AW +: SPR_AW]), s_addr[i]);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic reset_mid();
        @(negedge clk);
        pix_ce = 0; wr_en = 0; valid_in = 0;
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check("rst_rgb", 32'(rgb), 0);
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        check("rst_collide", 32'(collide), 0);
        check("rst_bg_addr", 32'(bg_addr), 0);
        check("rst_spr_addr", 32'(spr_addr), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int x, y, r;
        bit v;
        for (int i = 0; i < NUM_SPR; i++)
            for (int a = 0; a < int'(ROM_N); a++)
                spr_rom[i][a] = ($urandom_range(0, 9) < 3) ? KEY : 8'($urandom);
        model_reset();
        #1 rst_n = 0;
        #20;
        check("init_rgb", 32'(rgb), 0);
        check("init_valid_out", 32'(valid_out), 0);
        check("init_frame_tick", 32'(frame_tick), 0);
        check("init_collide", 32'(collide), 0);
        @(negedge clk);
        rst_n = 1;

        // Background only, constant background byte, visible and blank pixels
        bg_const = 1;
        for (int k = 0; k < 40; k++) begin
            x = $urandom_range(1, 799);
            y = $urandom_range(0, 524);
            step(1, x, y, (x < 640) && (y < 480));
        end
        step(1, 10, 10, 1);
        step(1, 11, 10, 1);
        check("t1_bg_const", 32'(rgb), 32'h1C);

        // Pending write invisible until the tick, then sprite 1 frame 1
        bg_const = 0;
        spr_rom[1][9'h100] = 8'hFF;
        q_write(1, 100, 50, 1, 1);
        step(1, 100, 50, 1);
        step(1, 101, 50, 1);
        check("t2_pre_tick_bg", 32'(rgb), 32'hA5);
        step(1, 0, TICK_LINE, 0);
        step(1, 100, 50, 1);
        check("t2_spr_addr1", 32'(spr_addr[SPR_AW +: SPR_AW]), 32'h100);
        step(1, 101, 50, 1);
        check("t2_rgb", 32'(rgb), 32'hFF);

        // Priority and colour key
        q_write(0, 200, 200, 0, 1);
        step(0, 0, 0, 0);
        q_write(1, 200, 200, 0, 1);
        step(0, 0, 0, 0);
        spr_rom[0][0] = KEY;
        spr_rom[1][0] = 8'h5A;
        step(1, 0, TICK_LINE, 0);
        step(1, 200, 200, 1);
        step(1, 201, 200, 1);
        check("t3_key_shows_spr1", 32'(rgb), 32'h5A);
        spr_rom[0][0] = 8'h03;
        step(1, 200, 200, 1);
        step(1, 201, 200, 1);
        check("t3_spr0_wins", 32'(rgb), 32'h03);

        // Right-edge clipping, no wrap; out-of-range write index ignored
        q_write(2, 1020, 10, 0, 1);
        step(1, 0, TICK_LINE, 0);
        spr_rom[2][3] = 8'h77;
        step(1, 1, 10, 1);
        step(1, 1023, 10, 1);
        check("t4_no_wrap", 32'(rgb), 32'hA0);
        check("t4_spr_addr2", 32'(spr_addr[2*SPR_AW +: SPR_AW]), 32'h003);
        step(1, 1023, 11, 1);
        check("t4_clip_hit", 32'(rgb), 32'h77);
        spr_rom[3][429] = 8'h99;
        q_write(7, 1010, 20, 1, 1);
        step(1, 0, TICK_LINE, 0);
        step(1, 1023, 30, 1);
        step(1, 0, 0, 0);
        check("t4_idx7_ignored", 32'(rgb), 32'h55);

        // Write on the tick clk is taken immediately; mid-line reset
        q_write(1, 400, 400, 0, 1);
        spr_rom[1][0] = 8'h3C;
        step(1, 0, TICK_LINE, 0);
        step(1, 400, 400, 1);
        step(1, 401, 400, 1);
        check("t5_write_through", 32'(rgb), 32'h3C);
        step(1, 402, 400, 1);
        reset_mid();
        step(1, 400, 400, 1);
        step(1, 401, 400, 1);
        check("t5_post_reset_bg", 32'(rgb), 32'h09);

        // One-pixel overlap of sprites 0 and 2, then moved apart
        q_write(0, 300, 300, 0, 1);
        step(0, 0, 0, 0);
        q_write(2, 315, 315, 0, 1);
        step(0, 0, 0, 0);
        spr_rom[0][15*16+15] = 8'h11;
        spr_rom[2][0] = 8'h22;
        step(1, 0, TICK_LINE, 0);
        step(1, 315, 315, 1);
        step(1, 316, 315, 1);
        check("t6_overlap_rgb", 32'(rgb), 32'h11);
        step(1, 0, TICK_LINE, 0);
`ifdef COLLISION_EN
        check("t6_collide_set", 32'(collide), 32'h4);
`endif
        step(1, 315, 315, 1);
        step(1, 316, 315, 1);
        q_write(2, 500, 500, 0, 1);
        step(1, 0, TICK_LINE, 0);
`ifdef COLLISION_EN
        check("t6_collide_prev_frame", 32'(collide), 32'h4);
`endif
        step(1, 315, 315, 1);
        step(1, 316, 315, 1);
        step(1, 0, TICK_LINE, 0);
        check("t6_collide_clear", 32'(collide), 32'h0);

        // Randomized traffic in a small window plus the right edge
        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                q_write($urandom_range(0, 7),
                        ($urandom_range(0, 9) < 8) ? $urandom_range(0, 60) : $urandom_range(1000, 1023),
                        $urandom_range(0, 60), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 99) < 5) begin
                step(1, 0, TICK_LINE, $urandom_range(0, 1) == 1);
            end else begin
                x = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 70) : $urandom_range(990, 1023);
                y = $urandom_range(0, 70);
                v = $urandom_range(0, 4) != 0;
                step($urandom_range(0, 3) != 0, x, y, v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
